// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and its width.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  // 2'd3 is unused and steers back to IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// master = producer of operands and consumer of results; slave = the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// One-bit half adder; used in pairs by full_adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full_adder reused WIDTH times per operation.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Operands are taken only in IDLE (in_ready=1); the result is offered in
// DONE (out_valid=1) and sum/cout hold steady until out_ready is seen high.
// Producers must keep in_valid and the operands stable until in_ready.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus,
  output state_t       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             fa_s;
  logic             fa_cout;

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_cout)
  );

  // FSM, datapath shift registers and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            carry      <= bus.cin;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_sh;
  assign bus.cout      = carry;
  assign state_dbg     = state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios at WIDTH=8 plus randomized
// back-to-back traffic at WIDTH=8 and WIDTH=13 against an arithmetic model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(13)) if13 ();
  state_t st8;
  state_t st13;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(if8), .state_dbg(st8)
  );
  serial_adder #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .bus(if13), .state_dbg(st13)
  );

  int n_cmp;
  int n_bad;
  logic [16:0] exp_q[$];
  bit bad_state;
  bit [3:0] seen8;
  bit [3:0] seen13;

  // State coverage / illegal-state watch.
  always @(negedge clk) begin
    if (!rst) begin
      if (st8 == 2'd3 || st13 == 2'd3) bad_state = 1'b1;
      seen8[int'(st8)]   = 1'b1;
      seen13[int'(st13)] = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [16:0] model_add(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
    longint s;
    s = longint'(a) + longint'(b) + longint'(c);
    return 17'(s % (longint'(1) << (w + 1)));
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic get_in_ready(input int w);
    return (w == 8) ? if8.in_ready : if13.in_ready;
  endfunction

  function automatic logic get_out_valid(input int w);
    return (w == 8) ? if8.out_valid : if13.out_valid;
  endfunction

  function automatic logic [16:0] read_result(input int w);
    return (w == 8) ? {8'b0, if8.cout, if8.sum} : {3'b0, if13.cout, if13.sum};
  endfunction

  task automatic drive_in(input int w, input logic v, input logic [15:0] a,
                          input logic [15:0] b, input logic c);
    if (w == 8) begin
      if8.in_valid = v; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = c;
    end else begin
      if13.in_valid = v; if13.a = a[12:0]; if13.b = b[12:0]; if13.cin = c;
    end
  endtask

  task automatic drive_ready(input int w, input logic v);
    if (w == 8) if8.out_ready = v;
    else        if13.out_ready = v;
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic accept_op(input int w, input logic [15:0] a, input logic [15:0] b,
                           input logic c, output int ok, output int acc);
    ok  = 0;
    acc = 0;
    drive_in(w, 1'b1, a, b, c);
    for (int i = 0; i < 100; i++) begin
      if (get_in_ready(w)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 1) begin
      @(negedge clk);
      acc = cyc;
    end
    drive_in(w, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  // Counts negedges until out_valid; -1 when the bound runs out.
  task automatic wait_result(input int w, output int lat);
    lat = 0;
    while (!get_out_valid(w) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!get_out_valid(w)) lat = -1;
  endtask

  task automatic release_result(input int w);
    drive_ready(w, 1'b1);
    @(negedge clk);
    drive_ready(w, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++; if (if8.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", if8.in_ready); end
    n_cmp++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", if8.out_valid); end
    n_cmp++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", if8.busy); end
    n_cmp++; if ({if8.cout, if8.sum} !== 9'h000) begin n_bad++; $display("FAIL reset_result: got %h want 000", {if8.cout, if8.sum}); end
    n_cmp++; if (st8 !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", st8, IDLE); end
    n_cmp++; if (if13.in_ready !== 1'b1 || if13.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_w13: got in_ready=%b out_valid=%b want 1/0", if13.in_ready, if13.out_valid);
    end
  endtask

  task automatic test_basic();
    int ok, lat, acc;
    accept_op(8, 16'h5A, 16'h33, 1'b0, ok, acc);
    n_cmp++; if (ok != 1) begin n_bad++; $display("FAIL basic_accept: got %0d want 1", ok); end
    n_cmp++; if (if8.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", if8.busy); end
    wait_result(8, lat);
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_cmp++; if ({if8.cout, if8.sum} !== 9'h08D) begin n_bad++; $display("FAIL basic_sum: got %h want 08d", {if8.cout, if8.sum}); end
    release_result(8);
    n_cmp++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_release: got in_ready=%b out_valid=%b want 1/0", if8.in_ready, if8.out_valid);
    end
  endtask

  task automatic test_carry();
    int ok, lat, acc;
    accept_op(8, 16'hFF, 16'h01, 1'b0, ok, acc);
    wait_result(8, lat);
    n_cmp++; if (lat < 0 || {if8.cout, if8.sum} !== 9'h100) begin n_bad++; $display("FAIL carry_ff_01: got %h lat %0d want 100", {if8.cout, if8.sum}, lat); end
    release_result(8);
    accept_op(8, 16'hFF, 16'hFF, 1'b1, ok, acc);
    wait_result(8, lat);
    n_cmp++; if (lat < 0 || {if8.cout, if8.sum} !== 9'h1FF) begin n_bad++; $display("FAIL carry_ff_ff_1: got %h lat %0d want 1ff", {if8.cout, if8.sum}, lat); end
    release_result(8);
  endtask

  task automatic test_backpressure();
    int ok, lat, acc, held_bad;
    held_bad = 0;
    accept_op(8, 16'h3C, 16'h4B, 1'b1, ok, acc);
    wait_result(8, lat);
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL bp_latency: got %0d want 8", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if8.out_valid !== 1'b1 || {if8.cout, if8.sum} !== 9'h088) held_bad++;
    end
    n_cmp++; if (held_bad != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", held_bad); end
    release_result(8);
    n_cmp++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", if8.in_ready, if8.out_valid);
    end
  endtask

  task automatic test_ignore_in_valid();
    int ok, lat, acc, extra;
    extra = 0;
    accept_op(8, 16'h01, 16'h02, 1'b0, ok, acc);
    @(negedge clk);
    drive_in(8, 1'b1, 16'h11, 16'h00, 1'b0);
    @(negedge clk);
    n_cmp++; if (if8.in_ready !== 1'b0) begin n_bad++; $display("FAIL ign_in_ready: got %b want 0", if8.in_ready); end
    @(negedge clk);
    drive_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_result(8, lat);
    n_cmp++; if (lat < 0 || {if8.cout, if8.sum} !== 9'h003) begin n_bad++; $display("FAIL ign_result: got %h lat %0d want 003", {if8.cout, if8.sum}, lat); end
    release_result(8);
    for (int i = 0; i < 15; i++) begin
      if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) extra++;
      @(negedge clk);
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL ign_no_second: got %0d non-idle cycles want 0", extra); end
  endtask

  task automatic test_async_reset();
    int ok, lat, acc;
    accept_op(8, 16'hAA, 16'h55, 1'b1, ok, acc);
    repeat (3) @(negedge clk);
    n_cmp++; if (if8.busy !== 1'b1) begin n_bad++; $display("FAIL ar_busy_before: got %b want 1", if8.busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if8.out_valid !== 1'b0 || if8.busy !== 1'b0 || if8.in_ready !== 1'b1 || if8.sum !== 8'h00) begin
      n_bad++; $display("FAIL ar_immediate: got out_valid=%b busy=%b in_ready=%b sum=%h want 0/0/1/00",
                        if8.out_valid, if8.busy, if8.in_ready, if8.sum);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (if8.out_valid !== 1'b0 || st8 !== IDLE) begin n_bad++; $display("FAIL ar_after: got out_valid=%b state=%0d want 0/0", if8.out_valid, st8); end
    accept_op(8, 16'h10, 16'h20, 1'b0, ok, acc);
    wait_result(8, lat);
    n_cmp++; if (lat != 8 || {if8.cout, if8.sum} !== 9'h030) begin n_bad++; $display("FAIL ar_new_op: got %h lat %0d want 030 lat 8", {if8.cout, if8.sum}, lat); end
    release_result(8);
  endtask

  task automatic test_random(input int w, input int n);
    int ok, lat, acc, prev_acc, gap, stall;
    logic [15:0] mask, a, b;
    logic c;
    logic [16:0] exp, got;
    mask = 16'((32'd1 << w) - 1);
    prev_acc = 0;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      a = 16'($urandom) & mask;
      b = 16'($urandom) & mask;
      c = 1'($urandom_range(0, 1));
      exp_q.push_back(model_add(w, a, b, c));
      accept_op(w, a, b, c, ok, acc);
      if (ok != 1) begin
        n_cmp++; n_bad++; $display("FAIL rnd%0d_accept: got timeout want accept (op %0d)", w, k);
        break;
      end
      if (k > 0) begin
        n_cmp++; if (acc - prev_acc < w + 2) begin n_bad++; $display("FAIL rnd%0d_spacing: got %0d cycles want >= %0d", w, acc - prev_acc, w + 2); end
      end
      prev_acc = acc;
      drive_ready(w, 1'($urandom_range(0, 1)));
      wait_result(w, lat);
      n_cmp++; if (lat != w) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", w, lat, w); end
      if (lat < 0) break;
      exp = exp_q.pop_front();
      got = read_result(w);
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rnd%0d_sum: got %h want %h (a=%h b=%h cin=%b)", w, got, exp, a, b, c); end
      stall = $urandom_range(0, 3);
      if (stall > 0) begin
        drive_ready(w, 1'b0);
        repeat (stall) @(negedge clk);
        n_cmp++; if (get_out_valid(w) !== 1'b1 || read_result(w) !== exp) begin
          n_bad++; $display("FAIL rnd%0d_hold: got valid=%b %h want 1 %h", w, get_out_valid(w), read_result(w), exp);
        end
      end
      release_result(w);
    end
  endtask

  task automatic test_state_cov();
    n_cmp++; if (bad_state) begin n_bad++; $display("FAIL state_illegal: got state 3 seen want never"); end
    n_cmp++; if (seen8[2:0] !== 3'b111) begin n_bad++; $display("FAIL state_cov8: got %b want 111", seen8[2:0]); end
    n_cmp++; if (seen13[2:0] !== 3'b111) begin n_bad++; $display("FAIL state_cov13: got %b want 111", seen13[2:0]); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    drive_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
    drive_in(13, 1'b0, 16'h0, 16'h0, 1'b0);
    drive_ready(8, 1'b0);
    drive_ready(13, 1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_carry();
    test_backpressure();
    test_ignore_in_valid();
    test_async_reset();
    test_random(8, 1000);
    test_random(13, 1000);
    test_state_cov();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
